// File: rtl/core_pkg.sv
// Shared types and constants for the post-run memory dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    NEXT,
    DONE
  } state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;
  localparam int WORD_BYTES      = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with a registered, glitch-free txd line.
// Latency: txd drops to the start bit 1 cycle after start; frame is 10*CLK_PER_BIT cycles.
// Backpressure: start is accepted only while busy is low; busy is low in the final stop-bit cycle.
// Ports: clk, rstn (async active-low), start (pulse), data[7:0], busy, txd (idles high).
module uart_tx_byte
  import core_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW = $clog2(UART_FRAME_BITS);

  logic [TW-1:0]              timer_q, timer_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [UART_FRAME_BITS-1:0] frame_q, frame_d;
  logic                       active_q, active_d;
  logic                       txd_q, txd_d;
  logic                       bit_end, frame_end;

  assign bit_end   = active_q && (timer_q == TW'(CLK_PER_BIT - 1));
  assign frame_end = bit_end && (bit_q == BW'(UART_FRAME_BITS - 1));
  // Dropping busy during the last stop-bit cycle lets the next frame follow with no idle gap.
  assign busy      = active_q && !frame_end;
  assign txd       = txd_q;

  always_comb begin
    timer_d  = timer_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    active_d = active_q;
    txd_d    = txd_q;
    if (bit_end) begin
      timer_d = '0;
      bit_d   = bit_q + BW'(1);
      frame_d = {1'b1, frame_q[UART_FRAME_BITS-1:1]};
      txd_d   = frame_q[1];
    end else if (active_q) begin
      timer_d = timer_q + TW'(1);
    end
    if (frame_end) begin
      active_d = 1'b0;
      bit_d    = '0;
      txd_d    = 1'b1;
    end
    if (start && !busy) begin
      active_d = 1'b1;
      timer_d  = '0;
      bit_d    = '0;
      frame_d  = {1'b1, data, 1'b0};
      txd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_q  <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
      active_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps a window of data RAM over UART (4 bytes per word, LSB byte first) once the core ends.
// Latency: core_end edge to memread_io 2 cycles; data_ready_io to first start bit 1 cycle.
// Backpressure: none; waits indefinitely for data_ready_io, one outstanding read at a time.
// Ports: clk, rstn, core_end; RAM IO port addr_io/memread_io/data_from_memory_io/data_ready_io;
//        txd; status dump_busy, dump_done (sticky until reset).
module mem_dump_tx
  import core_pkg::*;
#(
  parameter int          CLK_PER_BIT = 868,
  parameter logic [31:0] DUMP_BASE   = 32'h0000_0000,
  parameter int          DUMP_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_end,
  output logic [31:0] addr_io,
  output logic        memread_io,
  input  logic [31:0] data_from_memory_io,
  input  logic        data_ready_io,
  output logic        txd,
  output logic        dump_busy,
  output logic        dump_done
);

  localparam int CW  = $clog2(DUMP_WORDS + 1);
  localparam int BYW = $clog2(WORD_BYTES);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BYW-1:0]  byte_q, byte_d;
  logic [BYW-1:0]  byte_nxt;
  logic            ce_q, ce_qq;
  logic            start_edge;
  logic            tx_start, tx_busy;
  logic [7:0]      tx_data;

  // Both copies reset low, so core_end already high at reset release still looks like an edge.
  assign start_edge = ce_q && !ce_qq;
  assign byte_nxt   = byte_q + BYW'(1);

  assign addr_io     = addr_q;
  assign memread_io  = (state_q == REQ);
  assign dump_busy   = (state_q == REQ) || (state_q == WAIT) || (state_q == SEND) || (state_q == NEXT);
  assign dump_done   = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    tx_start = 1'b0;
    tx_data  = word_q[8*byte_nxt +: 8];
    case (state_q)
      IDLE: if (start_edge) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (data_ready_io) begin
          // Byte 0 goes straight from the RAM bus so the start bit lands one cycle later.
          word_d   = data_from_memory_io;
          byte_d   = '0;
          tx_start = 1'b1;
          tx_data  = data_from_memory_io[7:0];
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          if (byte_q == BYW'(WORD_BYTES - 1)) begin
            state_d = NEXT;
          end else begin
            byte_d   = byte_nxt;
            tx_start = 1'b1;
          end
        end
      end
      NEXT: begin
        if (cnt_q == CW'(DUMP_WORDS - 1)) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 32'd4;
          cnt_d   = cnt_q + CW'(1);
          state_d = REQ;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= DUMP_BASE;
      word_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      ce_q    <= 1'b0;
      ce_qq   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      ce_q    <= core_end;
      ce_qq   <= ce_q;
    end
  end

  uart_tx_byte #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rstn (rstn),
    .start(tx_start),
    .data (tx_data),
    .busy (tx_busy),
    .txd  (txd)
  );

endmodule

// File: tb/tb_mem_dump_tx.sv
module tb_mem_dump_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: single word at base 0.  Index 1: two words starting at FFFF_FFFC (address wrap).
  logic        rstn_s[2];
  logic        core_end_s[2];
  logic [31:0] addr_s[2];
  logic        memread_s[2];
  logic [31:0] mdata_s[2];
  logic        mrdy_s[2];
  logic        txd_s[2];
  logic        busy_s[2];
  logic        done_s[2];

  mem_dump_tx #(.CLK_PER_BIT(CPB), .DUMP_BASE(32'h0000_0000), .DUMP_WORDS(1)) u_a (
    .clk(clk), .rstn(rstn_s[0]), .core_end(core_end_s[0]), .addr_io(addr_s[0]),
    .memread_io(memread_s[0]), .data_from_memory_io(mdata_s[0]), .data_ready_io(mrdy_s[0]),
    .txd(txd_s[0]), .dump_busy(busy_s[0]), .dump_done(done_s[0]));

  mem_dump_tx #(.CLK_PER_BIT(CPB), .DUMP_BASE(32'hFFFF_FFFC), .DUMP_WORDS(2)) u_b (
    .clk(clk), .rstn(rstn_s[1]), .core_end(core_end_s[1]), .addr_io(addr_s[1]),
    .memread_io(memread_s[1]), .data_from_memory_io(mdata_s[1]), .data_ready_io(mrdy_s[1]),
    .txd(txd_s[1]), .dump_busy(busy_s[1]), .dump_done(done_s[1]));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory + UART receiver reference model ----------------
  int          lat[2];
  logic [31:0] word_a;
  int          pend[2];
  int          rd_cnt[2];
  logic [31:0] rd_addr[2][4];
  int          first_rd_cyc[2];
  int          rdy_cyc[2][4];
  logic [31:0] ret_word[2][4];
  int          ret_n[2];
  bit          stray_req[2];
  int          wait_low[2];
  int          busy_gap[2];
  bit          rx_act[2];
  int          rx_cnt[2];
  logic [7:0]  rx_sh[2];
  int          rx_n[2];
  logic [7:0]  rx_byte[2][16];
  int          rx_start[2][16];
  int          frame_err[2];

  task automatic clear_model(input int d);
    pend[d] = 0; rd_cnt[d] = 0; first_rd_cyc[d] = -1; ret_n[d] = 0;
    stray_req[d] = 0; wait_low[d] = 0; busy_gap[d] = 0;
    rx_act[d] = 0; rx_cnt[d] = 0; rx_n[d] = 0; frame_err[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mrdy_s[d] = 1'b0;
      mdata_s[d] = 32'h0;
      clear_model(d);
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rstn_s[d]) begin
          pend[d] = 0;
          mrdy_s[d] = 1'b0;
          rx_act[d] = 0;
        end else begin
          mrdy_s[d] = 1'b0;
          if (stray_req[d]) begin
            mrdy_s[d] = 1'b1;
            mdata_s[d] = 32'hDEAD_BEEF;
            stray_req[d] = 0;
          end
          if (pend[d] > 0) begin
            if (txd_s[d] !== 1'b1) wait_low[d]++;
            pend[d]--;
            if (pend[d] == 0) begin
              logic [31:0] w;
              w = (d == 0) ? word_a : $urandom;
              if (ret_n[d] < 4) begin
                ret_word[d][ret_n[d]] = w;
                rdy_cyc[d][ret_n[d]] = cyc;
              end
              ret_n[d]++;
              mdata_s[d] = w;
              mrdy_s[d] = 1'b1;
            end
          end
          if (memread_s[d]) begin
            if (rd_cnt[d] < 4) rd_addr[d][rd_cnt[d]] = addr_s[d];
            if (rd_cnt[d] == 0) first_rd_cyc[d] = cyc;
            rd_cnt[d]++;
            pend[d] = lat[d];
          end
          if (rd_cnt[d] > 0 && !done_s[d] && !busy_s[d]) busy_gap[d]++;
          // UART receiver: sample the middle of each bit.
          if (!rx_act[d]) begin
            if (txd_s[d] === 1'b0) begin
              rx_act[d] = 1;
              rx_cnt[d] = 0;
              if (rx_n[d] < 16) rx_start[d][rx_n[d]] = cyc;
            end
          end else begin
            rx_cnt[d]++;
          end
          if (rx_act[d] && (rx_cnt[d] % CPB) == CPB / 2) begin
            int k;
            k = rx_cnt[d] / CPB;
            if (k == 0) begin
              if (txd_s[d] !== 1'b0) frame_err[d]++;
            end else if (k <= 8) begin
              rx_sh[d] = {txd_s[d], rx_sh[d][7:1]};
            end else begin
              if (txd_s[d] !== 1'b1) frame_err[d]++;
              if (rx_n[d] < 16) rx_byte[d][rx_n[d]] = rx_sh[d];
              rx_n[d]++;
              rx_act[d] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- vector table for the single-word instance ----------------
  typedef struct {
    logic [31:0] word;
    int          lat;
    bit          at_reset;
    bit          stray;
    bit          retrig;
    logic [31:0] exp_addr;
    int          exp_rd_delay;
  } vec_t;

  vec_t vecs[6];

  task automatic run_a(input vec_t v, input int idx);
    int t0;
    bit to;
    bit injected;
    int toggled;
    rstn_s[0] = 1'b0;
    core_end_s[0] = v.at_reset;
    lat[0] = v.lat;
    word_a = v.word;
    clear_model(0);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d reset txd", idx), txd_s[0], 1);
    check($sformatf("v%0d reset busy", idx), busy_s[0], 0);
    check($sformatf("v%0d reset done", idx), done_s[0], 0);
    check($sformatf("v%0d reset memread", idx), memread_s[0], 0);
    check($sformatf("v%0d reset addr", idx), addr_s[0], 32'h0);
    rstn_s[0] = 1'b1;
    t0 = cyc;
    if (!v.at_reset) begin
      @(negedge clk);
      core_end_s[0] = 1'b1;
      t0 = cyc;
    end
    to = 1; injected = 0; toggled = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (v.stray && !injected && rx_n[0] == 1) begin
        stray_req[0] = 1;
        injected = 1;
      end
      if (v.retrig && toggled == 0 && rx_n[0] == 2) begin
        core_end_s[0] = 1'b0;
        toggled = 1;
      end else if (toggled == 1) begin
        core_end_s[0] = 1'b1;
        toggled = 2;
      end
      if (done_s[0]) begin
        to = 0;
        break;
      end
    end
    check($sformatf("v%0d done timeout", idx), to, 0);
    repeat (2) @(negedge clk);
    check($sformatf("v%0d read count", idx), rd_cnt[0], 1);
    check($sformatf("v%0d read addr", idx), rd_addr[0][0], v.exp_addr);
    check($sformatf("v%0d start-to-read", idx), first_rd_cyc[0] - t0, v.exp_rd_delay);
    check($sformatf("v%0d byte count", idx), rx_n[0], 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("v%0d byte%0d", idx, i), {24'h0, rx_byte[0][i]}, (v.word >> (8 * i)) & 32'hFF);
    check($sformatf("v%0d framing", idx), frame_err[0], 0);
    check($sformatf("v%0d txd low in wait", idx), wait_low[0], 0);
    check($sformatf("v%0d ready-to-start", idx), rx_start[0][0] - rdy_cyc[0][0], 1);
    check($sformatf("v%0d 4 frames span", idx), rx_start[0][3] - rx_start[0][0], 3 * FRAME);
    check($sformatf("v%0d done", idx), done_s[0], 1);
    check($sformatf("v%0d busy after", idx), busy_s[0], 0);
    check($sformatf("v%0d txd idle", idx), txd_s[0], 1);
    if (v.retrig) begin
      core_end_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      core_end_s[0] = 1'b1;
      repeat (60) @(negedge clk);
      check($sformatf("v%0d retrig reads", idx), rd_cnt[0], 1);
      check($sformatf("v%0d retrig bytes", idx), rx_n[0], 4);
      check($sformatf("v%0d retrig done", idx), done_s[0], 1);
      check($sformatf("v%0d retrig busy", idx), busy_s[0], 0);
    end
  endtask

  task automatic start_b();
    rstn_s[1] = 1'b0;
    core_end_s[1] = 1'b0;
    lat[1] = $urandom_range(1, 10);
    clear_model(1);
    repeat (3) @(negedge clk);
    rstn_s[1] = 1'b1;
    @(negedge clk);
    core_end_s[1] = 1'b1;
  endtask

  initial begin
    bit to;
    for (int d = 0; d < 2; d++) begin
      rstn_s[d] = 1'b0;
      core_end_s[d] = 1'b0;
      lat[d] = 1;
    end
    word_a = 32'h0;

    vecs[0] = '{32'hA55A_0F81, 3, 1'b0, 1'b0, 1'b0, 32'h0, 2};
    vecs[1] = '{$urandom, 50, 1'b0, 1'b1, 1'b0, 32'h0, 2};
    vecs[2] = '{$urandom, 1, 1'b1, 1'b0, 1'b0, 32'h0, 2};
    vecs[3] = '{$urandom, int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b1, 32'h0, 2};
    vecs[4] = '{32'h0000_00FF, 2, 1'b1, 1'b0, 1'b1, 32'h0, 2};
    vecs[5] = '{$urandom, 8, 1'b0, 1'b1, 1'b1, 32'h0, 2};

    for (int i = 0; i < 6; i++) run_a(vecs[i], i);

    // Reset while done: status must clear without a clock edge.
    #2 rstn_s[0] = 1'b0;
    #1 check("A async reset done", done_s[0], 0);
    check("A async reset txd", txd_s[0], 1);
    @(negedge clk);

    // Two-word dump across the 32-bit address wrap.
    start_b();
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_s[1]) begin
        to = 0;
        break;
      end
    end
    check("B done timeout", to, 0);
    repeat (2) @(negedge clk);
    check("B read count", rd_cnt[1], 2);
    check("B read addr0", rd_addr[1][0], 32'hFFFF_FFFC);
    check("B read addr1", rd_addr[1][1], 32'h0000_0000);
    check("B byte count", rx_n[1], 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("B byte%0d", i), {24'h0, rx_byte[1][i]}, (ret_word[1][i / 4] >> (8 * (i % 4))) & 32'hFF);
    check("B framing", frame_err[1], 0);
    check("B busy gap", busy_gap[1], 0);
    check("B txd low in wait", wait_low[1], 0);
    check("B done", done_s[1], 1);

    // Reset in the middle of a second-word frame.
    start_b();
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_n[1] >= 5) begin
        to = 0;
        break;
      end
    end
    check("B mid timeout", to, 0);
    repeat (CPB + 2) @(negedge clk);
    #2 rstn_s[1] = 1'b0;
    #1 check("B async reset txd", txd_s[1], 1);
    check("B async reset busy", busy_s[1], 0);
    check("B async reset done", done_s[1], 0);
    check("B async reset addr", addr_s[1], 32'hFFFF_FFFC);
    @(negedge clk);
    core_end_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    rstn_s[1] = 1'b1;
    repeat (100) @(negedge clk);
    check("B no resume reads", rd_cnt[1], 2);
    check("B no resume bytes", rx_n[1], 5);
    check("B no resume txd", txd_s[1], 1);
    check("B no resume busy", busy_s[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
